// File: rtl/terminal_arb_pkg.sv
// Shared types and constants for the two-station terminal arbiter.
// Optional timeout preemption is enabled with the TERMINAL_ARB_PREEMPT_EN macro.
package terminal_arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } state_e;

    localparam logic STN0        = 1'b0;
    localparam logic STN1        = 1'b1;
    localparam logic TERM_MATRIZ = 1'b0;
    localparam logic TERM_LEDS   = 1'b1;
    localparam int   CODE_IDLE   = 0;
    localparam int   CODE_W_DFLT = 3;

endpackage

// File: rtl/terminal_owner_fsm.sv
// Ownership FSM for one terminal: grant, hold, release and round-robin tie-break.
// With TERMINAL_ARB_PREEMPT_EN defined, an expired hold counter lets a waiting station preempt.
module terminal_owner_fsm
    import terminal_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int CODE_W      = CODE_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              want0,
    input  logic              want1,
    input  logic              rel0,
    input  logic              rel1,
    input  logic              req0,
    input  logic              req1,
    input  logic [CODE_W-1:0] cf0,
    input  logic [CODE_W-1:0] cf1,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              owner,
    output logic              valid_nxt,
    output logic              owner_nxt
);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic [CODE_W-1:0] code_q, code_d;

    logic              grant_ev;
    logic              grant_stn;
    logic              own_rel;
    logic              own_req;
    logic              own_want;
    logic              preempt;
    logic [CODE_W-1:0] own_cf;

    assign own_rel   = owner_q ? rel1  : rel0;
    assign own_req   = owner_q ? req1  : req0;
    assign own_want  = owner_q ? want1 : want0;
    assign own_cf    = owner_q ? cf1   : cf0;
    assign grant_ev  = (state_q == ST_IDLE) && (want0 || want1);
    // On a tie the station that was not served last wins.
    assign grant_stn = (want0 && want1) ? ~last_q : want1;

`ifdef TERMINAL_ARB_PREEMPT_EN
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign preempt = (cnt_q == '0) && (owner_q ? want0 : want1);

    always_comb begin
        cnt_d = cnt_q;
        if (grant_ev) begin
            cnt_d = CNT_W'(HOLD_CYCLES - 1);
        end else if (state_q == ST_OWNED && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        valid_d = valid_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_ev) begin
                    state_d = ST_OWNED;
                    owner_d = grant_stn;
                    last_d  = grant_stn;
                    valid_d = 1'b1;
                    code_d  = grant_stn ? cf1 : cf0;
                end
            end
            ST_OWNED: begin
                // A lost want with REQ still high means SEL moved to the other terminal.
                if (own_rel || !own_req || !own_want || preempt) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    code_d  = CODE_W'(CODE_IDLE);
                end else begin
                    code_d  = own_cf;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                code_d  = CODE_W'(CODE_IDLE);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= STN0;
            last_q  <= STN1;
            valid_q <= 1'b0;
            code_q  <= CODE_W'(CODE_IDLE);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    assign code      = code_q;
    assign valid     = valid_q;
    assign owner     = owner_q;
    assign valid_nxt = valid_d;
    assign owner_nxt = owner_d;

endmodule

// File: rtl/terminal_arbiter.sv
// Shares the matrix and LED terminals between two stations with registered outputs.
// Define TERMINAL_ARB_PREEMPT_EN to enable timeout preemption after HOLD_CYCLES.
module terminal_arbiter
    import terminal_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int CODE_W      = CODE_W_DFLT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic [CODE_W-1:0] CF0,
    input  logic              SEL0,
    input  logic              REL0,
    input  logic              REQ1,
    input  logic [CODE_W-1:0] CF1,
    input  logic              SEL1,
    input  logic              REL1,
    output logic [CODE_W-1:0] FMATRIZ,
    output logic [CODE_W-1:0] FLEDS,
    output logic              OWN_M_VALID,
    output logic              OWN_M_ID,
    output logic              OWN_L_VALID,
    output logic              OWN_L_ID,
    output logic              WAIT0,
    output logic              WAIT1
);

    logic want0_m, want0_l, want1_m, want1_l;
    logic m_valid_nxt, m_owner_nxt, l_valid_nxt, l_owner_nxt;
    logic wait0_q, wait0_d, wait1_q, wait1_d;

    assign want0_m = REQ0 && (SEL0 == TERM_MATRIZ);
    assign want0_l = REQ0 && (SEL0 == TERM_LEDS);
    assign want1_m = REQ1 && (SEL1 == TERM_MATRIZ);
    assign want1_l = REQ1 && (SEL1 == TERM_LEDS);

    terminal_owner_fsm #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CODE_W      (CODE_W)
    ) u_fsm_matriz (
        .clk       (CLK),
        .rst       (RST),
        .want0     (want0_m),
        .want1     (want1_m),
        .rel0      (REL0),
        .rel1      (REL1),
        .req0      (REQ0),
        .req1      (REQ1),
        .cf0       (CF0),
        .cf1       (CF1),
        .code      (FMATRIZ),
        .valid     (OWN_M_VALID),
        .owner     (OWN_M_ID),
        .valid_nxt (m_valid_nxt),
        .owner_nxt (m_owner_nxt)
    );

    terminal_owner_fsm #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CODE_W      (CODE_W)
    ) u_fsm_leds (
        .clk       (CLK),
        .rst       (RST),
        .want0     (want0_l),
        .want1     (want1_l),
        .rel0      (REL0),
        .rel1      (REL1),
        .req0      (REQ0),
        .req1      (REQ1),
        .cf0       (CF0),
        .cf1       (CF1),
        .code      (FLEDS),
        .valid     (OWN_L_VALID),
        .owner     (OWN_L_ID),
        .valid_nxt (l_valid_nxt),
        .owner_nxt (l_owner_nxt)
    );

    // WAIT is judged against next-cycle ownership so it lines up with the registered grants.
    always_comb begin
        wait0_d = (want0_m && !(m_valid_nxt && m_owner_nxt == STN0))
               || (want0_l && !(l_valid_nxt && l_owner_nxt == STN0));
        wait1_d = (want1_m && !(m_valid_nxt && m_owner_nxt == STN1))
               || (want1_l && !(l_valid_nxt && l_owner_nxt == STN1));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wait0_q <= 1'b0;
            wait1_q <= 1'b0;
        end else begin
            wait0_q <= wait0_d;
            wait1_q <= wait1_d;
        end
    end

    assign WAIT0 = wait0_q;
    assign WAIT1 = wait1_q;

endmodule
